// File: rtl/rv32_trap_pkg.sv
// Package: rv32_trap_pkg
// Shared definitions for the machine-mode trap controller.
// Contents: FSM state encoding, mcause exception and interrupt codes,
// PC mux select constants, the registered control-output bundle, and
// the helper that decodes that bundle from a state.
// Optional feature macro: TRAP_CTRL_WFI_EN adds the S_WFI state.
package rv32_trap_pkg;

   typedef enum logic [2:0] {
      S_RESET       = 3'd0,
      S_OPERATING   = 3'd1,
      S_TRAP_TAKEN  = 3'd2,
      S_TRAP_RETURN = 3'd3
`ifdef TRAP_CTRL_WFI_EN
      , S_WFI       = 3'd4
`endif
   } state_t;

   // Exception codes (mcause[31] = 0)
   localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
   localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   // Interrupt codes (mcause[31] = 1)
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   // PC mux select
   localparam logic [1:0] PC_SRC_BOOT = 2'b00;
   localparam logic [1:0] PC_SRC_NEXT = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP = 2'b10;
   localparam logic [1:0] PC_SRC_MEPC = 2'b11;

   // Strobes and selects that are held in flops and presented per state
   typedef struct packed {
      logic       set_cause;
      logic       misaligned_exception;
      logic       set_epc;
      logic       mie_clear;
      logic       mie_set;
      logic       flush;
      logic [1:0] pc_src;
   } ctrl_t;

   // Only address-misaligned exceptions put a faulting address into mtval
   function automatic logic is_misaligned_code(input logic [3:0] cause);
      return (cause == CAUSE_MISALIGNED_INSTR) ||
             (cause == CAUSE_MISALIGNED_LOAD)  ||
             (cause == CAUSE_MISALIGNED_STORE);
   endfunction

   function automatic ctrl_t decode_ctrl(input state_t st,
                                         input logic [3:0] cause,
                                         input logic is_int);
      ctrl_t c;
      c = '0;
      case (st)
         S_RESET: begin
            c.pc_src = PC_SRC_BOOT;
            c.flush  = 1'b1;
         end
         S_OPERATING: c.pc_src = PC_SRC_NEXT;
         S_TRAP_TAKEN: begin
            c.set_cause            = 1'b1;
            c.set_epc              = 1'b1;
            c.mie_clear            = 1'b1;
            c.pc_src               = PC_SRC_TRAP;
            c.flush                = 1'b1;
            c.misaligned_exception = !is_int && is_misaligned_code(cause);
         end
         S_TRAP_RETURN: begin
            c.mie_set = 1'b1;
            c.pc_src  = PC_SRC_MEPC;
            c.flush   = 1'b1;
         end
`ifdef TRAP_CTRL_WFI_EN
         S_WFI: c.pc_src = PC_SRC_NEXT;
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/trap_cause_enc_rv32.sv
// Module: trap_cause_enc_rv32
// Combinational priority encoder from exception/interrupt sources to a
// trap request.
// Ports:
//   exception sources (misaligned_instr, illegal_instr, ebreak, ecall,
//   misaligned_load, misaligned_store), mie (mstatus.MIE), meie/mtie/msie
//   enables, meip/mtip/msip pending lines          -> inputs
//   trap_valid   trap requested (exception, or enabled irq with mie)
//   int_or_exc   1 = the request is an interrupt
//   cause        mcause code of the winning source
//   irq_pending  some enabled irq is pending, independent of mie
//   irq_cause    code of the highest-priority enabled pending irq
module trap_cause_enc_rv32 (
   input  logic       misaligned_instr,
   input  logic       illegal_instr,
   input  logic       ebreak,
   input  logic       ecall,
   input  logic       misaligned_load,
   input  logic       misaligned_store,
   input  logic       mie,
   input  logic       meie,
   input  logic       mtie,
   input  logic       msie,
   input  logic       meip,
   input  logic       mtip,
   input  logic       msip,
   output logic       trap_valid,
   output logic       int_or_exc,
   output logic [3:0] cause,
   output logic       irq_pending,
   output logic [3:0] irq_cause
);
   import rv32_trap_pkg::*;

   logic       exc_valid;
   logic [3:0] exc_cause;

   always_comb begin
      // NOTE: every variable gets a default before the priority chain so no
      // path leaves it unassigned, which would infer a latch.
      exc_valid = 1'b1;
      exc_cause = CAUSE_MISALIGNED_INSTR;
      if (misaligned_instr)      exc_cause = CAUSE_MISALIGNED_INSTR;
      else if (illegal_instr)    exc_cause = CAUSE_ILLEGAL_INSTR;
      else if (ebreak)           exc_cause = CAUSE_BREAKPOINT;
      else if (ecall)            exc_cause = CAUSE_ECALL_M;
      else if (misaligned_load)  exc_cause = CAUSE_MISALIGNED_LOAD;
      else if (misaligned_store) exc_cause = CAUSE_MISALIGNED_STORE;
      else                       exc_valid = 1'b0;
   end

   always_comb begin
      irq_pending = (meip & meie) | (msip & msie) | (mtip & mtie);
      if (meip & meie)      irq_cause = CAUSE_MEI;
      else if (msip & msie) irq_cause = CAUSE_MSI;
      else                  irq_cause = CAUSE_MTI;
   end

   // Exceptions always win; interrupts only count when globally enabled
   assign trap_valid = exc_valid | (mie & irq_pending);
   assign int_or_exc = !exc_valid & mie & irq_pending;
   assign cause      = exc_valid ? exc_cause : irq_cause;

endmodule

// File: rtl/trap_ctrl_rv32.sv
// Module: trap_ctrl_rv32
// Machine-mode trap control FSM. Sequences trap entry, MRET and PC
// redirection, and produces the strobes for mcause/mtval/mepc/mstatus.
// Parameter: RESET_HOLD (1..15) cycles spent in S_RESET.
// Optional feature macro: TRAP_CTRL_WFI_EN adds wfi_in and the S_WFI state.
// Ports:
//   clk_in, rst_in (async active-low), ready_in (FSM advances only when 1)
//   exception sources, mret_in, mie_in, interrupt enables/pending -> inputs
//   set_cause_out, misaligned_exception_out, cause_out, int_or_exc_out,
//   set_epc_out, mie_clear_out, mie_set_out   -> CSR file
//   instret_inc_out                            -> minstret
//   pc_src_out, flush_out                      -> fetch stage
// Strobes are held while ready_in=0; consumers act on (strobe & ready_in).
module trap_ctrl_rv32 #(
   parameter int RESET_HOLD = 1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       ready_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       ecall_in,
   input  logic       ebreak_in,
   input  logic       mret_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
`ifdef TRAP_CTRL_WFI_EN
   input  logic       wfi_in,
`endif
   output logic       set_cause_out,
   output logic       misaligned_exception_out,
   output logic [3:0] cause_out,
   output logic       int_or_exc_out,
   output logic       set_epc_out,
   output logic       mie_clear_out,
   output logic       mie_set_out,
   output logic       instret_inc_out,
   output logic [1:0] pc_src_out,
   output logic       flush_out
);
   import rv32_trap_pkg::*;

   localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD);

   logic       trap_valid;
   logic       trap_int;
   logic [3:0] trap_cause;
   logic       irq_pending;
   logic [3:0] irq_cause;

   state_t     state_q, state_n;
   logic [3:0] hold_q, hold_n;
   logic [3:0] cause_q, cause_n;
   logic       int_q, int_n;
   logic       retire;
   ctrl_t      ctrl_q;

   trap_cause_enc_rv32 u_enc (
      .misaligned_instr (misaligned_instr_in),
      .illegal_instr    (illegal_instr_in),
      .ebreak           (ebreak_in),
      .ecall            (ecall_in),
      .misaligned_load  (misaligned_load_in),
      .misaligned_store (misaligned_store_in),
      .mie              (mie_in),
      .meie             (meie_in),
      .mtie             (mtie_in),
      .msie             (msie_in),
      .meip             (meip_in),
      .mtip             (mtip_in),
      .msip             (msip_in),
      .trap_valid       (trap_valid),
      .int_or_exc       (trap_int),
      .cause            (trap_cause),
      .irq_pending      (irq_pending),
      .irq_cause        (irq_cause)
   );

   always_comb begin
      state_n = state_q;
      hold_n  = hold_q;
      cause_n = cause_q;
      int_n   = int_q;
      retire  = 1'b0;
      case (state_q)
         // The first clock after reset loads the S_RESET outputs; the
         // counter then spans RESET_HOLD visible boot cycles.
         S_RESET: begin
            if (hold_q == HOLD_LAST) state_n = S_OPERATING;
            else                     hold_n  = hold_q + 4'd1;
         end
         S_OPERATING: begin
            if (trap_valid) begin
               state_n = S_TRAP_TAKEN;
               cause_n = trap_cause;
               int_n   = trap_int;
            end else if (mret_in) begin
               state_n = S_TRAP_RETURN;
`ifdef TRAP_CTRL_WFI_EN
            end else if (wfi_in) begin
               // WFI itself retires; sleeping starts on the next cycle
               state_n = S_WFI;
               retire  = 1'b1;
`endif
            end else begin
               retire = 1'b1;
            end
         end
         S_TRAP_TAKEN, S_TRAP_RETURN: state_n = S_OPERATING;
`ifdef TRAP_CTRL_WFI_EN
         // Wake on any enabled pending irq; only trap if globally enabled
         S_WFI: begin
            if (irq_pending) begin
               if (mie_in) begin
                  state_n = S_TRAP_TAKEN;
                  cause_n = irq_cause;
                  int_n   = 1'b1;
               end else begin
                  state_n = S_OPERATING;
               end
            end
         end
`endif
         default: state_n = S_RESET;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_RESET;
         hold_q  <= 4'd0;
         cause_q <= 4'd0;
         int_q   <= 1'b0;
         ctrl_q  <= '0;
      end else if (ready_in) begin
         state_q <= state_n;
         hold_q  <= hold_n;
         cause_q <= cause_n;
         int_q   <= int_n;
         ctrl_q  <= decode_ctrl(state_n, cause_n, int_n);
      end
   end

   assign set_cause_out            = ctrl_q.set_cause;
   assign misaligned_exception_out = ctrl_q.misaligned_exception;
   assign set_epc_out              = ctrl_q.set_epc;
   assign mie_clear_out            = ctrl_q.mie_clear;
   assign mie_set_out              = ctrl_q.mie_set;
   assign pc_src_out               = ctrl_q.pc_src;
   assign flush_out                = ctrl_q.flush;
   assign cause_out                = cause_q;
   assign int_or_exc_out           = int_q;
   // Retirement is only known in the cycle it happens, so it is qualified
   // by the live ready and trap decision rather than held in a flop.
   assign instret_inc_out          = retire & ready_in;

endmodule

// File: tb/tb_trap_ctrl_rv32.sv
// Testbench: tb_trap_ctrl_rv32
// Directed stimulus with hand-computed per-cycle expected outputs pushed
// into a scoreboard queue; an independent monitor pops and compares on
// every falling clock edge while entries are queued.
// Vector layout: {set_cause, misaligned_exception, cause[3:0], int_or_exc,
//                 set_epc, mie_clear, mie_set, instret_inc, pc_src[1:0], flush}
// Define TRAP_CTRL_WFI_EN to also exercise the WFI state.
module tb_trap_ctrl_rv32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ready = 1'b1;
   logic       illegal_instr = 1'b0, misaligned_instr = 1'b0;
   logic       misaligned_load = 1'b0, misaligned_store = 1'b0;
   logic       ecall = 1'b0, ebreak = 1'b0, mret = 1'b0;
   logic       mie = 1'b0, meie = 1'b0, mtie = 1'b0, msie = 1'b0;
   logic       meip = 1'b0, mtip = 1'b0, msip = 1'b0;
`ifdef TRAP_CTRL_WFI_EN
   logic       wfi = 1'b0;
`endif

   logic       set_cause, mis_exc, int_or_exc, set_epc, mie_clear, mie_set;
   logic       instret_inc, flush;
   logic [3:0] cause;
   logic [1:0] pc_src;

   trap_ctrl_rv32 #(.RESET_HOLD(1)) dut (
      .clk_in                   (clk),
      .rst_in                   (rst_n),
      .ready_in                 (ready),
      .illegal_instr_in         (illegal_instr),
      .misaligned_instr_in      (misaligned_instr),
      .misaligned_load_in       (misaligned_load),
      .misaligned_store_in      (misaligned_store),
      .ecall_in                 (ecall),
      .ebreak_in                (ebreak),
      .mret_in                  (mret),
      .mie_in                   (mie),
      .meie_in                  (meie),
      .mtie_in                  (mtie),
      .msie_in                  (msie),
      .meip_in                  (meip),
      .mtip_in                  (mtip),
      .msip_in                  (msip),
`ifdef TRAP_CTRL_WFI_EN
      .wfi_in                   (wfi),
`endif
      .set_cause_out            (set_cause),
      .misaligned_exception_out (mis_exc),
      .cause_out                (cause),
      .int_or_exc_out           (int_or_exc),
      .set_epc_out              (set_epc),
      .mie_clear_out            (mie_clear),
      .mie_set_out              (mie_set),
      .instret_inc_out          (instret_inc),
      .pc_src_out               (pc_src),
      .flush_out                (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [13:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic logic [13:0] ev(bit sc, bit me, logic [3:0] c, bit i,
                                      bit se, bit mc, bit ms, bit ir,
                                      logic [1:0] pc, bit fl);
      return {sc, me, c, i, se, mc, ms, ir, pc, fl};
   endfunction

   task automatic check(input string name, input logic [13:0] act,
                        input logic [13:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // Monitor: one scoreboard entry per cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name,
                  {set_cause, mis_exc, cause, int_or_exc, set_epc, mie_clear,
                   mie_set, instret_inc, pc_src, flush},
                  e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Queue this cycle's expectation, then advance to just after the next edge
   task automatic step(input string name, input logic [13:0] e);
      exp_t x;
      x.name = name;
      x.exp  = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      illegal_instr = 0; misaligned_instr = 0; misaligned_load = 0;
      misaligned_store = 0; ecall = 0; ebreak = 0; mret = 0;
      mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
`ifdef TRAP_CTRL_WFI_EN
      wfi = 0;
`endif
   endtask

   logic [13:0] z, boot;

   initial begin
      z    = ev(0,0,4'd0,0,0,0,0,0,2'b00,0);
      boot = ev(0,0,4'd0,0,0,0,0,0,2'b00,1);
      @(posedge clk);
      #1;
      // Reset and boot hold
      step("reset", z);
      rst_n = 1'b1;
      step("rst_release", z);
      step("boot_hold", boot);
      step("op_first",  ev(0,0,4'd0,0,0,0,0,1,2'b01,0));
      step("op_second", ev(0,0,4'd0,0,0,0,0,1,2'b01,0));

      // Misaligned load
      misaligned_load = 1;
      step("mload_detect", ev(0,0,4'd0,0,0,0,0,0,2'b01,0));
      clr();
      step("mload_trap",   ev(1,1,4'd4,0,1,1,0,0,2'b10,1));
      step("mload_resume", ev(0,0,4'd4,0,0,0,0,1,2'b01,0));

      // Exception beats a simultaneous enabled interrupt
      illegal_instr = 1; mtip = 1; mtie = 1; mie = 1;
      step("illegal_detect", ev(0,0,4'd4,0,0,0,0,0,2'b01,0));
      clr();
      step("illegal_trap",   ev(1,0,4'd2,0,1,1,0,0,2'b10,1));

      // All irqs pending and enabled: masked by mie=0, then taken
      meip = 1; mtip = 1; msip = 1; meie = 1; mtie = 1; msie = 1; mie = 0;
      step("irq_masked",  ev(0,0,4'd2,0,0,0,0,1,2'b01,0));
      step("irq_masked2", ev(0,0,4'd2,0,0,0,0,1,2'b01,0));
      mie = 1;
      step("irq_detect",  ev(0,0,4'd2,0,0,0,0,0,2'b01,0));
      clr();
      step("mei_trap",     ev(1,0,4'd11,1,1,1,0,0,2'b10,1));
      step("op_after_irq", ev(0,0,4'd11,1,0,0,0,1,2'b01,0));

      // ECALL outranks misaligned store
      ecall = 1; misaligned_store = 1;
      step("ecall_detect", ev(0,0,4'd11,1,0,0,0,0,2'b01,0));
      clr();
      step("ecall_trap",   ev(1,0,4'd11,0,1,1,0,0,2'b10,1));

      // MRET
      mret = 1;
      step("mret_detect",   ev(0,0,4'd11,0,0,0,0,0,2'b01,0));
      clr();
      step("mret_return",   ev(0,0,4'd11,0,0,0,1,0,2'b11,1));
      step("op_after_mret", ev(0,0,4'd11,0,0,0,0,1,2'b01,0));

      // MRET with 3 cycles of ready=0 in the return state
      mret = 1;
      step("mret2_detect", ev(0,0,4'd11,0,0,0,0,0,2'b01,0));
      clr();
      ready = 0;
      for (int i = 0; i < 3; i++)
         step($sformatf("mret2_stall%0d", i), ev(0,0,4'd11,0,0,0,1,0,2'b11,1));
      ready = 1;
      step("mret2_release",  ev(0,0,4'd11,0,0,0,1,0,2'b11,1));
      step("op_after_stall", ev(0,0,4'd11,0,0,0,0,1,2'b01,0));

      // ready=0 suppresses retirement
      ready = 0;
      step("op_stall",  ev(0,0,4'd11,0,0,0,0,0,2'b01,0));
      ready = 1;
      step("op_resume", ev(0,0,4'd11,0,0,0,0,1,2'b01,0));

      // Exception beats MRET; misaligned instr has top priority
      misaligned_instr = 1; ebreak = 1; mret = 1;
      step("minstr_detect", ev(0,0,4'd11,0,0,0,0,0,2'b01,0));
      clr();
      step("minstr_trap",   ev(1,1,4'd0,0,1,1,0,0,2'b10,1));
      step("op_end",        ev(0,0,4'd0,0,0,0,0,1,2'b01,0));

      // Reset asserted mid-trap aborts at once
      misaligned_store = 1;
      step("mstore_detect", ev(0,0,4'd0,0,0,0,0,0,2'b01,0));
      clr();
      rst_n = 1'b0;
      step("abort_reset", z);
      rst_n = 1'b1;
      step("abort_release", z);
      step("abort_hold", boot);
      step("abort_op", ev(0,0,4'd0,0,0,0,0,1,2'b01,0));

`ifdef TRAP_CTRL_WFI_EN
      // WFI woken by an enabled irq with mie=0: no trap
      wfi = 1;
      step("wfi_enter", ev(0,0,4'd0,0,0,0,0,1,2'b01,0));
      clr();
      for (int i = 0; i < 5; i++)
         step($sformatf("wfi_sleep%0d", i), ev(0,0,4'd0,0,0,0,0,0,2'b01,0));
      mtip = 1; mtie = 1; mie = 0;
      step("wfi_wake_masked", ev(0,0,4'd0,0,0,0,0,0,2'b01,0));
      clr();
      step("wfi_no_trap", ev(0,0,4'd0,0,0,0,0,1,2'b01,0));

      // WFI woken with mie=1: timer interrupt trap
      wfi = 1;
      step("wfi_enter2", ev(0,0,4'd0,0,0,0,0,1,2'b01,0));
      clr();
      for (int i = 0; i < 5; i++)
         step($sformatf("wfi2_sleep%0d", i), ev(0,0,4'd0,0,0,0,0,0,2'b01,0));
      mtip = 1; mtie = 1; mie = 1;
      step("wfi_wake", ev(0,0,4'd0,0,0,0,0,0,2'b01,0));
      clr();
      step("wfi_mti_trap", ev(1,0,4'd7,1,1,1,0,0,2'b10,1));
      step("wfi_done",     ev(0,0,4'd7,1,0,0,0,1,2'b01,0));
`endif

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
      end
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
